// File: rtl/branch_cc_unit.sv
// Branch resolution unit: N/Z/P condition-code register fed by ALU writeback,
// branch evaluation with same-cycle bypass, and a registered valid/ready result.
module branch_cc_unit #(
    parameter int N = 19,
    parameter int M = 3,
    parameter int C = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cc_we,
    input  logic [N:0]   cc_value,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M:0]   opc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         jump_select,
    input  logic         flush,
    output logic [2:0]   cc_flags,
    output logic [C-1:0] taken_count
);

    // {n,z,p}: exactly one bit set for any two's-complement value
    function automatic logic [2:0] decode(input logic [N:0] v);
        logic z;
        z = (v == '0);
        return {v[N], z, ~v[N] & ~z};
    endfunction

    logic [2:0]   cc_q, cc_d;
    logic         valid_q, valid_d;
    logic         js_q, js_d;
    logic [C-1:0] cnt_q, cnt_d;

    logic [2:0] eff_flags;
    logic       taken;
    logic       accept;
    logic       deliver;

    if (M > 3) begin : g_opc_hi
        logic unused_opc_hi;
        assign unused_opc_hi = ^opc[M:4];
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        eff_flags = cc_we ? decode(cc_value) : cc_q;
        taken     = opc[3] | (opc[2] & eff_flags[2]) | (opc[1] & eff_flags[1])
                  | (opc[0] & eff_flags[0]);
        in_ready  = ~valid_q | out_ready;
        accept    = in_valid & in_ready;
        deliver   = valid_q & out_ready & ~flush;

        cc_d    = cc_we ? decode(cc_value) : cc_q;
        valid_d = valid_q;
        js_d    = js_q;
        if (flush) begin
            valid_d = 1'b0;
            js_d    = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            js_d    = taken;
        end else if (valid_q & out_ready) begin
            valid_d = 1'b0;
            js_d    = 1'b0;
        end

        // A result handed over alongside a new accept still counts as delivered.
        cnt_d = cnt_q;
        if (deliver & js_q & (cnt_q != '1)) begin
            cnt_d = cnt_q + C'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q    <= 3'b010;
            valid_q <= 1'b0;
            js_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cc_q    <= cc_d;
            valid_q <= valid_d;
            js_q    <= js_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        out_valid   = valid_q;
        jump_select = js_q;
        cc_flags    = cc_q;
        taken_count = cnt_q;
    end

endmodule

// File: tb/tb_branch_cc_unit.sv
// Self-checking bench for branch_cc_unit: a C=16 and a C=2 instance share stimulus
// and are compared every cycle against a behavioural model plus literal expectations.
module tb_branch_cc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        cc_we;
    logic [19:0] cc_value;
    logic        in_valid;
    logic [3:0]  opc;
    logic        out_ready;
    logic        flush;

    logic        in_ready_a, out_valid_a, js_a;
    logic [2:0]  cc_flags_a;
    logic [15:0] cnt_a;
    logic        in_ready_b, out_valid_b, js_b;
    logic [2:0]  cc_flags_b;
    logic [1:0]  cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_cc_unit #(.N(19), .M(3), .C(16)) u_dut (
        .clk(clk), .rst(rst), .cc_we(cc_we), .cc_value(cc_value),
        .in_valid(in_valid), .in_ready(in_ready_a), .opc(opc),
        .out_valid(out_valid_a), .out_ready(out_ready), .jump_select(js_a),
        .flush(flush), .cc_flags(cc_flags_a), .taken_count(cnt_a)
    );

    branch_cc_unit #(.N(19), .M(3), .C(2)) u_dut2 (
        .clk(clk), .rst(rst), .cc_we(cc_we), .cc_value(cc_value),
        .in_valid(in_valid), .in_ready(in_ready_b), .opc(opc),
        .out_valid(out_valid_b), .out_ready(out_ready), .jump_select(js_b),
        .flush(flush), .cc_flags(cc_flags_b), .taken_count(cnt_b)
    );

    // Behavioural model: sign/zero test of the value, branch taken if
    // unconditional or the opcode bit matching the current flag is set.
    function automatic logic [2:0] flags_of(input logic [19:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 20'd0)     return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic taken_of(input logic [3:0] op, input logic [2:0] f);
        int idx;
        idx = (f == 3'b100) ? 2 : (f == 3'b010) ? 1 : 0;
        return op[3] || op[idx];
    endfunction

    logic [2:0] m_cc;
    logic       m_valid, m_js;
    int         m_cnt16, m_cnt2;

    always @(posedge clk) begin
        logic [2:0] f;
        if (rst) begin
            m_cc = 3'b010; m_valid = 1'b0; m_js = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
        end else begin
            f = cc_we ? flags_of(cc_value) : m_cc;
            if (m_valid && out_ready && !flush && m_js) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3)      m_cnt2++;
            end
            if (flush) begin
                m_valid = 1'b0; m_js = 1'b0;
            end else if (in_valid && (!m_valid || out_ready)) begin
                m_valid = 1'b1; m_js = taken_of(opc, f);
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0; m_js = 1'b0;
            end
            if (cc_we) m_cc = flags_of(cc_value);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic m_in_ready;
        m_in_ready = !m_valid || out_ready;
        check("model cc_flags",    32'(cc_flags_a),  32'(m_cc));
        check("model out_valid",   32'(out_valid_a), 32'(m_valid));
        check("model jump_select", 32'(js_a),        32'(m_js));
        check("model in_ready",    32'(in_ready_a),  32'(m_in_ready));
        check("model count16",     32'(cnt_a),       32'(m_cnt16));
        check("model c2 out_valid", 32'(out_valid_b), 32'(m_valid));
        check("model c2 jump",     32'(js_b),        32'(m_js));
        check("model count2",      32'(cnt_b),       32'(m_cnt2));
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle();
        cc_we = 1'b0; cc_value = 20'd0; in_valid = 1'b0; opc = 4'd0;
        out_ready = 1'b1; flush = 1'b0;
    endtask

    logic [19:0] vals [4] = '{20'h80000, 20'h00000, 20'h00001, 20'h7FFFF};

    initial begin
        // Reset with every input active
        rst = 1'b1; cc_we = 1'b1; cc_value = 20'h80000; in_valid = 1'b1; opc = 4'hF;
        out_ready = 1'b1; flush = 1'b1;
        tick(); tick();
        check("rst cc_flags", 32'(cc_flags_a), 32'h2);
        check("rst out_valid", 32'(out_valid_a), 32'h0);
        check("rst jump", 32'(js_a), 32'h0);
        check("rst count", 32'(cnt_a), 32'h0);
        rst = 1'b0; idle(); out_ready = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready_a), 32'h1);
        out_ready = 1'b1;

        // Negative flags, N branch taken, Z branch not taken
        cc_we = 1'b1; cc_value = 20'h80000;
        tick();
        check("neg cc_flags", 32'(cc_flags_a), 32'h4);
        cc_we = 1'b0; in_valid = 1'b1; opc = 4'b0100;
        tick();
        check("N taken", 32'(js_a), 32'h1);
        opc = 4'b0010;
        tick();
        check("Z not taken", 32'(js_a), 32'h0);
        check("Z not taken valid", 32'(out_valid_a), 32'h1);
        in_valid = 1'b0;
        tick();
        check("count after two", 32'(cnt_a), 32'h1);

        // Bypass from writeback
        cc_we = 1'b1; cc_value = 20'h00000; in_valid = 1'b1; opc = 4'b0010;
        tick();
        check("bypass Z jump", 32'(js_a), 32'h1);
        check("bypass Z flags", 32'(cc_flags_a), 32'h2);
        cc_value = 20'h00001; opc = 4'b0001;
        tick();
        check("bypass P jump", 32'(js_a), 32'h1);
        check("bypass P flags", 32'(cc_flags_a), 32'h1);
        idle();
        tick();
        check("bypass count", 32'(cnt_a), 32'h3);

        // Backpressure: A taken held, B stalled
        out_ready = 1'b0; in_valid = 1'b1; opc = 4'b1000;
        tick();
        opc = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold in_ready", 32'(in_ready_a), 32'h0);
            check("hold jump", 32'(js_a), 32'h1);
        end
        out_ready = 1'b1;
        tick();
        check("swap valid", 32'(out_valid_a), 32'h1);
        check("swap B jump", 32'(js_a), 32'h0);
        check("swap count", 32'(cnt_a), 32'h4);
        in_valid = 1'b0;
        tick();

        // Flush drops a held result and a simultaneous accept
        in_valid = 1'b1; opc = 4'b1000;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        tick();
        check("flush valid", 32'(out_valid_a), 32'h0);
        check("flush count", 32'(cnt_a), 32'h4);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("flush accept dropped", 32'(out_valid_a), 32'h0);
        idle();
        tick();
        check("flush count after", 32'(cnt_a), 32'h4);

        // opc=0 never taken, opc=0111 always taken, across all flag states
        in_valid = 1'b1; cc_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 2; j++) begin
                cc_value = vals[i];
                opc = (j == 0) ? 4'b0000 : 4'b0111;
                tick();
                check("opc0/opc7 jump", 32'(js_a), 32'(j));
            end
        end
        idle();
        tick();

        // Saturation of the C=2 counter after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b1; opc = 4'b1000;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) in_valid = 1'b0;
            tick();
            check("c2 saturate", 32'(cnt_b), (i == 0) ? 32'd1 : (i == 1) ? 32'd2 : 32'd3);
        end
        check("c16 count five", 32'(cnt_a), 32'd5);

        // Reset mid-stream with a result held
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check("pre-rst valid", 32'(out_valid_a), 32'h1);
        rst = 1'b1; cc_we = 1'b1; cc_value = 20'h00001; flush = 1'b1;
        tick();
        check("midrst valid", 32'(out_valid_a), 32'h0);
        check("midrst jump", 32'(js_a), 32'h0);
        check("midrst flags", 32'(cc_flags_a), 32'h2);
        check("midrst count", 32'(cnt_a), 32'h0);
        check("midrst count2", 32'(cnt_b), 32'h0);
        check("midrst in_ready", 32'(in_ready_a), 32'h1);
        rst = 1'b0; idle();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
